// File: rtl/ipsxe_floating_point_lzc_scan_ctrl_v1_0.sv
// ---------------------------------------------------------------------------
// ipsxe_floating_point_lzc_scan_ctrl_v1_0
//
// Sequential leading-one scan controller for the fixed-to-float path.
// A single 16-bit leading-one detector is time-shared over the operand:
// one 16-bit segment is examined per clock, starting at the most significant
// segment, and the scan stops at the first non-zero segment. The result
// (leading-one position, normalise shift, zero flag) is held together with
// the latched operand until the downstream side accepts it.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_valid  : operand valid          o_ready : operand can be accepted
//   i_data   : operand to scan
//   o_valid  : result valid (held)    i_ready : downstream accepts result
//   o_pos    : bit index of the leading one
//   o_shift  : DATA_WIDTH-1-o_pos, left shift needed to normalise
//   o_zero   : operand was all zeros
//   o_data   : latched operand, stable while o_valid is high
//
// DATA_WIDTH must be one of 16, 32, 48, 64.
// ---------------------------------------------------------------------------
module ipsxe_floating_point_lzc_scan_ctrl_v1_0 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [5:0]            o_pos,
    output logic [5:0]            o_shift,
    output logic                  o_zero,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int         NSEG    = DATA_WIDTH / 16;
    localparam logic [1:0] SEG_TOP = 2'(NSEG - 1);
    localparam logic [5:0] POS_MAX = 6'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [1:0]              seg_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    zero_q;
    logic [5:0]              pos_q;
    logic [5:0]              shift_q;

    // Segment view of the latched operand
    logic [15:0] seg_words [NSEG];

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        assign seg_words[gi] = data_q[gi*16 +: 16];
    end

    // Segment currently under the shared detector
    logic [15:0] seg_word;

    always_comb begin
        seg_word = seg_words[0];
        for (int k = 1; k < NSEG; k++) begin
            if (seg_q == 2'(k)) begin
                seg_word = seg_words[k];
            end
        end
    end

    // Shared 16-bit leading-one detector. The ascending loop lets the
    // highest set bit overwrite every lower one, so the MSB wins.
    logic [3:0] lod_idx;
    logic       lod_nz;

    always_comb begin
        lod_idx = 4'd0;
        for (int b = 0; b < 16; b++) begin
            if (seg_word[b]) begin
                lod_idx = 4'(b);
            end
        end
    end

    assign lod_nz = |seg_word;

    // seg*16 + lod(s) is just the concatenation of the two indices
    logic [5:0] pos_d;
    logic [5:0] shift_d;

    assign pos_d   = {seg_q, lod_idx};
    assign shift_d = POS_MAX - pos_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            seg_q   <= 2'd0;
            data_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            pos_q   <= 6'd0;
            shift_q <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && ready_q) begin
                        data_q  <= i_data;
                        seg_q   <= SEG_TOP;
                        ready_q <= 1'b0;
                        state_q <= SCAN;
                    end else begin
                        // Also raises o_ready on the first edge after reset
                        ready_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (lod_nz) begin
                        pos_q   <= pos_d;
                        shift_q <= shift_d;
                        zero_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else if (seg_q == 2'd0) begin
                        pos_q   <= 6'd0;
                        shift_q <= POS_MAX;
                        zero_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        seg_q <= seg_q - 2'd1;
                    end
                end
                DONE: begin
                    // o_ready stays low here, so an i_valid in the
                    // handshake cycle is only taken one cycle later
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_pos   = pos_q;
    assign o_shift = shift_q;
    assign o_zero  = zero_q;
    assign o_data  = data_q;

endmodule
